// File: rtl/button_pulse_gen.sv
// Debounced up/down pushbuttons to single-cycle inc/dec requests,
// with hold-to-repeat and a lockout when both buttons are held.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    output logic inc,
    output logic dec,
    output logic up_level,
    output logic dn_level
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                            DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int W      = $clog2(MAX_P);

    localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
    localparam logic [W-1:0] RD_LAST = W'(REPEAT_DELAY - 1);
    localparam logic [W-1:0] RR_LAST = W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        IDLE, HOLD_UP, RPT_UP, HOLD_DN, RPT_DN, LOCK
    } state_t;

    // bit 0 = up channel, bit 1 = down channel
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        lvl;
    logic [1:0][W-1:0] db_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            lvl    <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= {btn_dn, btn_up};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + W'(1);
                end
            end
        end
    end

    assign up_level = lvl[0];
    assign dn_level = lvl[1];

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   timer;
    logic [W-1:0]   timer_nxt;
    logic           inc_nxt;
    logic           dec_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            inc   <= 1'b0;
            dec   <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            inc   <= inc_nxt;
            dec   <= dec_nxt;
        end
    end

    // Release beats opposite press; both beat the repeat timer.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (up_level && dn_level) begin
                    state_nxt = LOCK;
                end else if (up_level) begin
                    state_nxt = HOLD_UP;
                    inc_nxt   = 1'b1;
                end else if (dn_level) begin
                    state_nxt = HOLD_DN;
                    dec_nxt   = 1'b1;
                end
            end
            HOLD_UP, RPT_UP: begin
                if (!up_level) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (dn_level) begin
                    state_nxt = LOCK;
                    timer_nxt = '0;
                end else if (timer == ((state == HOLD_UP) ? RD_LAST : RR_LAST)) begin
                    state_nxt = RPT_UP;
                    inc_nxt   = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + W'(1);
                end
            end
            HOLD_DN, RPT_DN: begin
                if (!dn_level) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (up_level) begin
                    state_nxt = LOCK;
                    timer_nxt = '0;
                end else if (timer == ((state == HOLD_DN) ? RD_LAST : RR_LAST)) begin
                    state_nxt = RPT_DN;
                    dec_nxt   = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + W'(1);
                end
            end
            LOCK: begin
                timer_nxt = '0;
                if (!up_level && !dn_level) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with small debounce/repeat
// parameters; i counts posedges since the last input change.
module tb_button_pulse_gen;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_dn;
    logic inc;
    logic dec;
    logic up_level;
    logic dn_level;

    int n_cmp = 0;
    int n_bad = 0;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .inc(inc),
        .dec(dec),
        .up_level(up_level),
        .dn_level(dn_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({inc, dec, up_level, dn_level} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_async got=%b want=0000",
                     {inc, dec, up_level, dn_level});
        end
        tick();
        tick();
        n_cmp++;
        if ({inc, dec, up_level, dn_level} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_held got=%b want=0000",
                     {inc, dec, up_level, dn_level});
        end
        reset = 1'b0;
    endtask

    task automatic test_glitch();
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        for (int i = 4; i <= 18; i++) begin
            tick();
            n_cmp++;
            if ({up_level, inc, dec} !== 3'b000) begin
                n_bad++;
                $display("FAIL glitch cyc=%0d got=%b want=000",
                         i, {up_level, inc, dec});
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] exp;
        btn_up = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            exp = {(i >= 6 && i <= 17), (i == 7), 1'b0};
            n_cmp++;
            if ({up_level, inc, dec} !== exp) begin
                n_bad++;
                $display("FAIL single cyc=%0d got=%b want=%b",
                         i, {up_level, inc, dec}, exp);
            end
            if (i == 12) btn_up = 1'b0;
        end
    endtask

    task automatic test_repeat();
        logic [2:0] exp;
        btn_up = 1'b1;
        for (int i = 1; i <= 46; i++) begin
            tick();
            exp = {(i >= 6),
                   (i == 7 || i == 27 || i == 32 || i == 37 || i == 42),
                   1'b0};
            n_cmp++;
            if ({up_level, inc, dec} !== exp) begin
                n_bad++;
                $display("FAIL repeat cyc=%0d got=%b want=%b",
                         i, {up_level, inc, dec}, exp);
            end
        end
        btn_up = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_lock();
        logic [3:0] exp;
        btn_up = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            exp = {(i >= 6 && i <= 80),
                   ((i >= 38 && i <= 65) || i >= 96),
                   (i == 7 || i == 27 || i == 32 || i == 37),
                   (i == 97)};
            n_cmp++;
            if ({up_level, dn_level, inc, dec} !== exp) begin
                n_bad++;
                $display("FAIL lock cyc=%0d got=%b want=%b",
                         i, {up_level, dn_level, inc, dec}, exp);
            end
            if (i == 32) btn_dn = 1'b1;
            if (i == 60) btn_dn = 1'b0;
            if (i == 75) btn_up = 1'b0;
            if (i == 90) btn_dn = 1'b1;
        end
        btn_dn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_both();
        logic [3:0] exp;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp = {(i >= 6), (i >= 6), 2'b00};
            n_cmp++;
            if ({up_level, dn_level, inc, dec} !== exp) begin
                n_bad++;
                $display("FAIL both cyc=%0d got=%b want=%b",
                         i, {up_level, dn_level, inc, dec}, exp);
            end
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_hold();
        logic [2:0] exp;
        btn_up = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp = {(i >= 6), (i == 7 || i == 27 || i == 32), 1'b0};
            n_cmp++;
            if ({up_level, inc, dec} !== exp) begin
                n_bad++;
                $display("FAIL prerst cyc=%0d got=%b want=%b",
                         i, {up_level, inc, dec}, exp);
            end
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({inc, dec, up_level, dn_level} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_async got=%b want=0000",
                     {inc, dec, up_level, dn_level});
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            exp = {(i >= 6), (i == 7 || i == 27 || i == 32), 1'b0};
            n_cmp++;
            if ({up_level, inc, dec} !== exp) begin
                n_bad++;
                $display("FAIL postrst cyc=%0d got=%b want=%b",
                         i, {up_level, inc, dec}, exp);
            end
        end
        btn_up = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_repeat();
        test_lock();
        test_both();
        test_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
